io_cycle_gen: RTL and testbench

IO_CYCLE_GEN -- requirements
Module: io_cycle_gen

---
 rtl/io_cycle_gen_pkg.sv | 15 +
 rtl/tstate_timer.sv | 25 ++
 rtl/io_cycle_gen.sv | 108 ++++++++++
 tb/tb_io_cycle_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/io_cycle_gen_pkg.sv
// Shared types and default timing constants for the Z80-style I/O cycle generator.
package common;

  localparam int unsigned DEFAULT_TDIV     = 8;
  localparam int unsigned DEFAULT_WAIT_MAX = 255;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } io_state_t;

endpackage

// File: rtl/tstate_timer.sv
// T-state divider: counts TDIV clk28 cycles per T-state, restartable on state entry.
module tstate_timer #(
  parameter int unsigned TDIV = 8
) (
  input  logic clk28,
  input  logic rst,
  input  logic restart,
  output logic last_tick
);

  localparam int unsigned CW = $clog2(TDIV);

  logic [CW-1:0] tick;

  assign last_tick = (tick == CW'(TDIV - 1));

  always_ff @(posedge clk28) begin
    if (rst || restart || last_tick) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/io_cycle_gen.sv
// Z80-style port I/O bus cycle generator: T1, T2, automatic TW (+ responder waits), T3.
module io_cycle_gen
  import common::*;
#(
  parameter int unsigned TDIV     = DEFAULT_TDIV,
  parameter int unsigned WAIT_MAX = DEFAULT_WAIT_MAX
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_d_oe,
  output logic        bus_ioreq,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_wait,
  input  logic [7:0]  resp_d,
  input  logic        resp_d_active
);

  localparam int unsigned WW = $clog2(WAIT_MAX + 1);

  io_state_t     state, state_next;
  logic          last_tick;
  logic          restart;
  logic          wr_q;
  logic          err_q;
  logic [WW-1:0] wait_cnt;
  logic          tw_end;
  logic          abort;

  tstate_timer #(
    .TDIV (TDIV)
  ) u_timer (
    .clk28     (clk28),
    .rst       (rst),
    .restart   (restart),
    .last_tick (last_tick)
  );

  assign tw_end = (state == TW) && last_tick;
  assign abort  = tw_end && bus_wait && (wait_cnt == WW'(WAIT_MAX - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req)       state_next = T1;
      T1:      if (last_tick) state_next = T2;
      T2:      if (last_tick) state_next = TW;
      TW:      if (last_tick && (!bus_wait || abort)) state_next = T3;
      T3:      if (last_tick) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Idle holds the divider at zero so T1 always starts on a fresh T-state boundary.
  always_comb begin
    restart = (state == IDLE) || (state_next != state) || tw_end;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      rdata    <= '1;
      bus_a    <= '0;
      bus_d    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        wr_q     <= req_wr;
        bus_a    <= req_addr;
        bus_d    <= req_wdata;
        err_q    <= 1'b0;
        wait_cnt <= '0;
      end
      if (abort) begin
        rdata <= '1;
        err_q <= 1'b1;
      end else if (tw_end && bus_wait) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else if (tw_end && !wr_q) begin
        rdata <= resp_d_active ? resp_d : 8'hFF;
      end
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    bus_ioreq = (state == T2) || (state == TW);
    bus_rd    = bus_ioreq && !wr_q;
    bus_wr    = bus_ioreq && wr_q;
    bus_d_oe  = wr_q && (state != IDLE);
    ack       = (state == T3) && last_tick && !rst;
    err       = ack && err_q;
  end

endmodule

// File: tb/tb_io_cycle_gen.sv
// Scoreboard bench for io_cycle_gen: expectations queued at request, checked at ack.
module tb_io_cycle_gen;

  localparam int T = 8;

  logic        clk28 = 1'b0;
  logic        rst, req, req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        busy, ack, err;
  logic [7:0]  rdata;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_d_oe, bus_ioreq, bus_rd, bus_wr;
  logic        bus_wait;
  logic [7:0]  resp_d;
  logic        resp_d_active;

  io_cycle_gen #(
    .TDIV     (T),
    .WAIT_MAX (4)
  ) dut (
    .clk28         (clk28),
    .rst           (rst),
    .req           (req),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .busy          (busy),
    .ack           (ack),
    .err           (err),
    .rdata         (rdata),
    .bus_a         (bus_a),
    .bus_d         (bus_d),
    .bus_d_oe      (bus_d_oe),
    .bus_ioreq     (bus_ioreq),
    .bus_rd        (bus_rd),
    .bus_wr        (bus_wr),
    .bus_wait      (bus_wait),
    .resp_d        (resp_d),
    .resp_d_active (resp_d_active)
  );

  always #5 clk28 = ~clk28;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    int          lat;
    int          rd_clks;
    int          wr_clks;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc, rd_clks, wr_clks;
  logic active = 1'b0;
  logic done   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Cycle-by-cycle observer; cyc = clocks since the acceptance edge.
  always @(negedge clk28) begin
    if (active) begin
      exp_t e;
      cyc++;
      if (bus_rd) rd_clks++;
      if (bus_wr) wr_clks++;
      e = sb[0];
      if (cyc == 1) begin
        check("t1_strobes", {bus_ioreq, bus_rd, bus_wr}, 3'b000);
        check("t1_addr", bus_a, e.addr);
        check("t1_oe", bus_d_oe, e.wr);
        check("t1_busy", busy, 1'b1);
        if (e.wr) check("t1_data", bus_d, e.wdata);
      end
      if (ack) begin
        check("sb_size", sb.size(), 1);
        e = sb.pop_front();
        check("lat", cyc, e.lat);
        check("rdata", rdata, e.rdata);
        check("err", err, e.err);
        check("rd_clks", rd_clks, e.rd_clks);
        check("wr_clks", wr_clks, e.wr_clks);
        check("ack_addr", bus_a, e.addr);
        check("ack_strobes", {bus_ioreq, bus_rd, bus_wr}, 3'b000);
        active = 1'b0;
        done   = 1'b1;
      end
    end else if (ack) begin
      check("spurious_ack", ack, 1'b0);
    end
  end

  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                        input logic ract, input logic [7:0] rd, input int nwait,
                        input logic [7:0] erd, input logic eerr, input int elat,
                        input int erdc, input int ewrc);
    exp_t e;
    e = '{wr: wr, addr: addr, wdata: wdata, rdata: erd, err: eerr,
          lat: elat, rd_clks: erdc, wr_clks: ewrc};
    sb.push_back(e);
    @(negedge clk28);
    req = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    resp_d_active = ract; resp_d = ~rd;
    @(posedge clk28);
    #1;
    req = 1'b0; req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata;
    cyc = 0; rd_clks = 0; wr_clks = 0; done = 1'b0; active = 1'b1;
    for (int c = 1; c <= 400 && !done; c++) begin
      @(negedge clk28);
      bus_wait = (c < (2 + nwait) * T + T / 2);
      resp_d   = bus_wait ? ~rd : rd;
    end
    check("timeout", done, 1'b1);
    if (!done) begin
      active = 1'b0;
      sb.delete();
    end
    bus_wait = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    bus_wait = 1'b0; resp_d = '0; resp_d_active = 1'b0;
    repeat (3) @(negedge clk28);
    check("rst_ctl", {busy, ack, err, bus_d_oe, bus_ioreq, bus_rd, bus_wr}, 7'b0);
    check("rst_rdata", rdata, 8'hFF);
    check("rst_bus_a", bus_a, 16'h0000);
    check("rst_bus_d", bus_d, 8'h00);
    rst = 1'b0;

    //      wr    addr      wdata  ract  rd     nw    rdata  err   lat    rd    wr
    do_txn(1'b1, 16'h00FE, 8'h07, 1'b0, 8'h00, 0,    8'hFF, 1'b0, 4*T,  0,    2*T);
    do_txn(1'b0, 16'h7FFD, 8'h00, 1'b1, 8'h5A, 0,    8'h5A, 1'b0, 4*T,  2*T,  0);
    do_txn(1'b0, 16'h00FF, 8'h00, 1'b0, 8'h77, 0,    8'hFF, 1'b0, 4*T,  2*T,  0);
    do_txn(1'b0, 16'h1234, 8'h00, 1'b1, 8'hC3, 3,    8'hC3, 1'b0, 7*T,  5*T,  0);
    do_txn(1'b0, 16'hABCD, 8'h00, 1'b1, 8'h99, 1000, 8'hFF, 1'b1, 7*T,  5*T,  0);

    // Reset pulsed in the middle of T2 of a write.
    @(negedge clk28);
    req = 1'b1; req_wr = 1'b1; req_addr = 16'h00FE; req_wdata = 8'h55;
    @(posedge clk28);
    #1 req = 1'b0;
    repeat (T + T / 2) @(negedge clk28);
    check("t2_wr", {bus_ioreq, bus_wr}, 2'b11);
    rst = 1'b1;
    @(negedge clk28);
    rst = 1'b0;
    check("rst_mid_ctl", {busy, bus_d_oe, bus_ioreq, bus_rd, bus_wr}, 5'b0);
    check("rst_mid_a", bus_a, 16'h0000);
    repeat (5 * T) @(negedge clk28);

    do_txn(1'b1, 16'h00FE, 8'h18, 1'b0, 8'h00, 0,    8'hFF, 1'b0, 4*T,  0,    2*T);
    do_txn(1'b1, 16'hBFFD, 8'hA5, 1'b0, 8'h00, 2,    8'hFF, 1'b0, 6*T,  0,    4*T);
    do_txn(1'b0, 16'hFFFD, 8'h00, 1'b1, 8'h3C, 0,    8'h3C, 1'b0, 4*T,  2*T,  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
